// File: rtl/md_pkg.sv
// Shared constants and types for the pre-intra gradient-histogram mode decision.
// Mode numbers, direction-bin and FSM encodings, and the bin classifier.
package md_pkg;

  localparam int unsigned FLAT_TH_DEFAULT = 288;
  localparam int unsigned ACC_W_DEFAULT   = 17;

  localparam logic [5:0] MODE_DC  = 6'd1;
  localparam logic [5:0] MODE_H   = 6'd10;
  localparam logic [5:0] MODE_D18 = 6'd18;
  localparam logic [5:0] MODE_V   = 6'd26;
  localparam logic [5:0] MODE_D2  = 6'd2;

  // Fetch stage is one cycle behind, so fetch counts 5..40 land here as 6..41.
  localparam logic [5:0] CNT_WIN_FIRST = 6'd6;
  localparam logic [5:0] CNT_WIN_LAST  = 6'd41;

  typedef enum logic [1:0] {
    BinV   = 2'd0,
    BinH   = 2'd1,
    BinD18 = 2'd2,
    BinD2  = 2'd3
  } bin_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StDec  = 2'd2,
    StDone = 2'd3
  } state_e;

  // tan(22.5deg) ~= 13/32; anything inside that cone is a pure V or H edge.
  function automatic bin_e grad_bin(input logic [9:0] a, input logic [9:0] b, input logic sgn);
    logic [14:0] a32, b32, a13, b13;
    bin_e        res;
    a32 = {a, 5'd0};
    b32 = {b, 5'd0};
    a13 = {5'd0, a} * 15'd13;
    b13 = {5'd0, b} * 15'd13;
    if (b32 < a13) begin
      res = BinV;
    end else if (a32 < b13) begin
      res = BinH;
    end else if (!sgn) begin
      res = BinD2;
    end else begin
      res = BinD18;
    end
    return res;
  endfunction

  function automatic logic [5:0] bin_mode(input bin_e bin);
    logic [5:0] res;
    unique case (bin)
      BinV:    res = MODE_V;
      BinH:    res = MODE_H;
      BinD18:  res = MODE_D18;
      BinD2:   res = MODE_D2;
      default: res = MODE_DC;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/md_grad_hist_if.sv
// Window-in / decision-out bundle between the fetch stage and md_grad_hist.
// master drives windows and the block counter; slave returns the decided mode.
interface md_grad_hist_if #(
  parameter int unsigned AMP_W = md_pkg::ACC_W_DEFAULT + 2
);
  logic             start;
  logic             enable;
  logic [5:0]       cnt;
  logic [23:0]      x1;
  logic [23:0]      x2;
  logic [23:0]      x3;
  logic [5:0]       mode_o;
  logic [AMP_W-1:0] amp_o;
  logic             done_o;

  modport master (
    output start, enable, cnt, x1, x2, x3,
    input  mode_o, amp_o, done_o
  );

  modport slave (
    input  start, enable, cnt, x1, x2, x3,
    output mode_o, amp_o, done_o
  );
endinterface

// File: rtl/md_sobel_core.sv
// Combinational 3x3 Sobel: returns |gx|, |gy| and whether gx and gy differ in sign.
// Byte [23:16] of each row is the leftmost pixel; x1 is the top row.
module md_sobel_core (
  input  logic [23:0] x1,
  input  logic [23:0] x2,
  input  logic [23:0] x3,
  output logic [9:0]  a,
  output logic [9:0]  b,
  output logic        sgn
);
  logic [7:0]  p00, p01, p02, p10, p12, p20, p21, p22;
  logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic [10:0] gx, gy;
  logic        unused_center;

  assign {p00, p01, p02} = x1;
  assign p10             = x2[23:16];
  assign p12             = x2[7:0];
  assign {p20, p21, p22} = x3;
  // Sobel kernels never weight the centre pixel.
  assign unused_center   = ^x2[15:8];

  assign gx_pos = {3'd0, p02} + {2'd0, p12, 1'b0} + {3'd0, p22};
  assign gx_neg = {3'd0, p00} + {2'd0, p10, 1'b0} + {3'd0, p20};
  assign gy_pos = {3'd0, p20} + {2'd0, p21, 1'b0} + {3'd0, p22};
  assign gy_neg = {3'd0, p00} + {2'd0, p01, 1'b0} + {3'd0, p02};

  // Range is +-1020, so 11-bit wraparound is exact two's complement.
  assign gx = gx_pos - gx_neg;
  assign gy = gy_pos - gy_neg;

  assign a   = gx[10] ? (~gx[9:0] + 10'd1) : gx[9:0];
  assign b   = gy[10] ? (~gy[9:0] + 10'd1) : gy[9:0];
  assign sgn = gx[10] ^ gy[10];

endmodule

// File: rtl/md_grad_hist.sv
// Per-8x8-block gradient direction histogram; picks one intra mode candidate
// (DC, H, V, D2 or D18) from the dominant Sobel direction over 36 windows.
module md_grad_hist
  import md_pkg::*;
#(
  parameter int unsigned FLAT_TH = FLAT_TH_DEFAULT,
  parameter int unsigned ACC_W   = ACC_W_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  md_grad_hist_if.slave bus
);
  localparam int unsigned       AMP_W     = ACC_W + 2;
  localparam logic [AMP_W-1:0] FLAT_TH_W = AMP_W'(FLAT_TH);

  state_e           state_q;
  logic             seen_q;
  logic [5:0]       mode_q;
  logic [AMP_W-1:0] amp_q;
  logic             done_q;

  logic             s1_vld_q;
  logic [9:0]       s1_a_q, s1_b_q;
  logic             s1_sgn_q;

  logic [ACC_W-1:0] bin_q [4];
  logic [AMP_W-1:0] total_q;

  logic             in_range;
  logic             win_vld;
  logic [9:0]       sob_a, sob_b;
  logic             sob_sgn;

  bin_e             s2_bin;
  logic [10:0]      s2_sum;
  logic             s2_upd;

  bin_e             best_bin;
  logic [ACC_W-1:0] best_val;
  logic [5:0]       dec_mode;

  assign in_range = (bus.cnt >= CNT_WIN_FIRST) && (bus.cnt <= CNT_WIN_LAST);
  assign win_vld  = (state_q == StAcc) && bus.enable && in_range;

  md_sobel_core u_sobel (
    .x1  (bus.x1),
    .x2  (bus.x2),
    .x3  (bus.x3),
    .a   (sob_a),
    .b   (sob_b),
    .sgn (sob_sgn)
  );

  assign s2_bin = grad_bin(s1_a_q, s1_b_q, s1_sgn_q);
  assign s2_sum = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign s2_upd = s1_vld_q && (s2_sum != 11'd0);

  // Strict '>' keeps the earlier bin on ties: V > H > D18 > D2.
  always_comb begin
    best_bin = BinV;
    best_val = bin_q[BinV];
    if (bin_q[BinH] > best_val) begin
      best_bin = BinH;
      best_val = bin_q[BinH];
    end
    if (bin_q[BinD18] > best_val) begin
      best_bin = BinD18;
      best_val = bin_q[BinD18];
    end
    if (bin_q[BinD2] > best_val) begin
      best_bin = BinD2;
      best_val = bin_q[BinD2];
    end
    dec_mode = (total_q < FLAT_TH_W) ? MODE_DC : bin_mode(best_bin);
  end

  // Window pipeline and accumulators; start restarts the block from scratch.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_sgn_q <= 1'b0;
      total_q  <= '0;
      for (int i = 0; i < 4; i++) bin_q[i] <= '0;
    end else if (bus.start) begin
      s1_vld_q <= 1'b0;
      total_q  <= '0;
      for (int i = 0; i < 4; i++) bin_q[i] <= '0;
    end else begin
      s1_vld_q <= win_vld;
      if (win_vld) begin
        s1_a_q   <= sob_a;
        s1_b_q   <= sob_b;
        s1_sgn_q <= sob_sgn;
      end
      if (s2_upd) begin
        bin_q[s2_bin] <= bin_q[s2_bin] + {{(ACC_W - 11){1'b0}}, s2_sum};
        total_q       <= total_q + {{(AMP_W - 11){1'b0}}, s2_sum};
      end
    end
  end

  // Leave ACC only once the window range is over and stage 1 has drained, so
  // enable gaps inside the range drop windows without ending the block early.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      seen_q  <= 1'b0;
      mode_q  <= '0;
      amp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        state_q <= StAcc;
        seen_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StIdle;
          StAcc: begin
            if (s1_vld_q) seen_q <= 1'b1;
            if ((seen_q || s1_vld_q) && !in_range) state_q <= StDec;
          end
          StDec: begin
            mode_q  <= dec_mode;
            amp_q   <= total_q;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.mode_o = mode_q;
  assign bus.amp_o  = amp_q;
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_md_grad_hist.sv
// Directed bench for md_grad_hist: whole 8x8 blocks are streamed by counter value
// and the decided mode, amplitude and done timing are compared with hand-computed values.
module tb_md_grad_hist;
  logic clk = 1'b0;
  logic rst;

  md_grad_hist_if bus ();

  md_grad_hist dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  int          done_cnt;
  int          ndone;
  logic [5:0]  got_mode;
  logic [18:0] got_amp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    assert (obs === exp_v)
    else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // 0 flat, 1 vertical edge, 2 horizontal edge, 3 anti-diagonal, 4 diagonal.
  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    case (pat)
      1:       return (c < 4) ? 8'd0 : 8'd255;
      2:       return (r < 4) ? 8'd0 : 8'd255;
      3:       return (r + c >= 8) ? 8'd255 : 8'd0;
      4:       return (c >= r) ? 8'd255 : 8'd0;
      default: return 8'd128;
    endcase
  endfunction

  // 5: one window gx=200; 6: one window gx=288; 7: one window gx=200 plus one gy=200.
  function automatic logic [23:0] win_row(input int pat, input int w, input int k);
    int r, c;
    r = w / 6;
    c = w % 6;
    case (pat)
      5:       return (w == 0) ? 24'h000032 : 24'h000000;
      6:       return (w == 0) ? 24'h000048 : 24'h000000;
      7: begin
        if (w == 0) return 24'h000032;
        if (w == 1 && k == 2) return 24'h323232;
        return 24'h000000;
      end
      default: return {pix(pat, r + k, c), pix(pat, r + k, c + 1), pix(pat, r + k, c + 2)};
    endcase
  endfunction

  task automatic run_block(input int pat, input int first, input int last, input int rst_at,
                           input int en_lo, input int en_hi);
    ndone    = 0;
    done_cnt = -1;
    got_mode = '0;
    got_amp  = '0;
    for (int v = first; v <= last; v++) begin
      bus.cnt    = 6'(v);
      bus.start  = (v == 5);
      rst        = (v == rst_at);
      bus.enable = !(v >= en_lo && v <= en_hi);
      if (v >= 6 && v <= 41) begin
        bus.x1 = win_row(pat, v - 6, 0);
        bus.x2 = win_row(pat, v - 6, 1);
        bus.x3 = win_row(pat, v - 6, 2);
      end else begin
        bus.x1 = 24'($urandom);
        bus.x2 = 24'($urandom);
        bus.x3 = 24'($urandom);
      end
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        ndone++;
        done_cnt = v;
        got_mode = bus.mode_o;
        got_amp  = bus.amp_o;
      end
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic check_block(input string tag, input int exp_mode, input int exp_amp);
    chk($sformatf("%s_ndone", tag), ndone, 1);
    chk($sformatf("%s_done_cnt", tag), done_cnt, 44);
    chk($sformatf("%s_mode", tag), {26'd0, got_mode}, exp_mode);
    chk($sformatf("%s_amp", tag), {13'd0, got_amp}, exp_amp);
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.enable = 1'b0;
    bus.cnt    = '0;
    bus.x1     = '0;
    bus.x2     = '0;
    bus.x3     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mode", {26'd0, bus.mode_o}, 0);
    chk("rst_amp", {13'd0, bus.amp_o}, 0);
    chk("rst_done", {31'd0, bus.done_o}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_block(0, 0, 47, -1, -1, -1);
    check_block("flat", 1, 0);

    run_block(1, 0, 47, -1, -1, -1);
    check_block("vert", 26, 12240);
    @(negedge clk);
    chk("vert_hold_mode", {26'd0, bus.mode_o}, 26);
    chk("vert_hold_done", {31'd0, bus.done_o}, 0);

    run_block(2, 0, 47, -1, -1, -1);
    check_block("horiz", 10, 12240);

    run_block(3, 0, 47, -1, -1, -1);
    check_block("diag_d2", 2, 21420);

    run_block(4, 0, 47, -1, -1, -1);
    check_block("diag_d18", 18, 21420);

    run_block(5, 0, 47, -1, -1, -1);
    check_block("weak", 1, 200);

    run_block(6, 0, 47, -1, -1, -1);
    check_block("flat_th_edge", 26, 288);

    run_block(7, 0, 47, -1, -1, -1);
    check_block("tie_vh", 26, 400);

    // First window row dropped: two of the twelve edge windows are lost.
    run_block(1, 0, 47, -1, 6, 11);
    check_block("enable_gap", 26, 10200);

    run_block(1, 0, 47, 20, -1, -1);
    chk("abort_ndone", ndone, 0);
    @(negedge clk);
    chk("abort_mode", {26'd0, bus.mode_o}, 0);
    chk("abort_amp", {13'd0, bus.amp_o}, 0);

    run_block(1, 0, 47, -1, -1, -1);
    check_block("after_abort", 26, 12240);

    // Horizontal block cut off mid-ACC by a fresh start; H must not leak through.
    run_block(2, 0, 20, -1, -1, -1);
    chk("restart_first_ndone", ndone, 0);
    run_block(1, 5, 47, -1, -1, -1);
    check_block("restart", 26, 12240);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
